// File: rtl/updown_counter_bank.sv
// Bank of independent 74193-style up/down counters with registered carry/borrow
// pulses, a reset-release enable delay, and selectable wrap or saturate arithmetic.
module updown_counter_bank #(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 4,
  parameter int ENABLE_DLY = 3,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       load_en,
  input  logic [NUM_CH*WIDTH-1:0] din,
  input  logic [NUM_CH-1:0]       inc_en,
  input  logic [NUM_CH-1:0]       dec_en,
  output logic [NUM_CH*WIDTH-1:0] dout,
  output logic [NUM_CH-1:0]       carry,
  output logic [NUM_CH-1:0]       borrow,
  output logic                    ready
);

  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [ENABLE_DLY-1:0] en_sr_r;
  logic [ENABLE_DLY-1:0] en_sr_next_s;

  // Enable delay line fills with ones from the LSB after reset release.
  always_comb begin
    en_sr_next_s = (en_sr_r << 1) | ENABLE_DLY'(1'b1);
  end

  // Enable delay line register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_sr_r <= {ENABLE_DLY{1'b0}};
    end else begin
      en_sr_r <= en_sr_next_s;
    end
  end

  assign ready = en_sr_r[ENABLE_DLY-1];

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_next_s;
    logic [WIDTH-1:0] din_s;
    logic             carry_r;
    logic             carry_next_s;
    logic             borrow_r;
    logic             borrow_next_s;

    assign din_s = din[ch*WIDTH +: WIDTH];

    // Per-channel next state: load beats inc/dec; simultaneous inc and dec cancel.
    always_comb begin
      cnt_next_s    = cnt_r;
      carry_next_s  = 1'b0;
      borrow_next_s = 1'b0;
      if (!ready) begin
        cnt_next_s = cnt_r;
      end else if (load_en[ch]) begin
        cnt_next_s = din_s;
      end else if (inc_en[ch] && dec_en[ch]) begin
        cnt_next_s = cnt_r;
      end else if (inc_en[ch]) begin
        if (cnt_r == MAX_VAL) begin
          carry_next_s = 1'b1;
          cnt_next_s   = SATURATE ? MAX_VAL : ZERO_VAL;
        end else begin
          cnt_next_s = cnt_r + ONE_VAL;
        end
      end else if (dec_en[ch]) begin
        if (cnt_r == ZERO_VAL) begin
          borrow_next_s = 1'b1;
          cnt_next_s    = SATURATE ? ZERO_VAL : MAX_VAL;
        end else begin
          cnt_next_s = cnt_r - ONE_VAL;
        end
      end else begin
        cnt_next_s = cnt_r;
      end
    end

    // Per-channel count and flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_r    <= ZERO_VAL;
        carry_r  <= 1'b0;
        borrow_r <= 1'b0;
      end else begin
        cnt_r    <= cnt_next_s;
        carry_r  <= carry_next_s;
        borrow_r <= borrow_next_s;
      end
    end

    assign dout[ch*WIDTH +: WIDTH] = cnt_r;
    assign carry[ch]               = carry_r;
    assign borrow[ch]              = borrow_r;
  end

endmodule

// File: tb/tb_updown_counter_bank.sv
// Randomized bench for updown_counter_bank: a wrap and a saturate instance share
// stimulus and are compared every cycle against a behavioural model.
module tb_updown_counter_bank;
  localparam int NUM_CH     = 4;
  localparam int WIDTH      = 4;
  localparam int ENABLE_DLY = 3;
  localparam int DW         = NUM_CH * WIDTH;
  localparam int MAXV       = (1 << WIDTH) - 1;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b1;
  logic [NUM_CH-1:0] load_en = '0;
  logic [NUM_CH-1:0] inc_en  = '0;
  logic [NUM_CH-1:0] dec_en  = '0;
  logic [DW-1:0]     din     = '0;

  logic [DW-1:0]     dout_w, dout_s;
  logic [NUM_CH-1:0] carry_w, carry_s, borrow_w, borrow_s;
  logic              ready_w, ready_s;

  int n_cmp  = 0;
  int n_fail = 0;

  // model state: index 0 = wrap instance, 1 = saturate instance
  int m_val[2][NUM_CH];
  bit m_car[2][NUM_CH];
  bit m_bor[2][NUM_CH];
  int m_edges = 0;

  always #5 clk = ~clk;

  updown_counter_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .ENABLE_DLY(ENABLE_DLY), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .load_en(load_en), .din(din), .inc_en(inc_en), .dec_en(dec_en),
    .dout(dout_w), .carry(carry_w), .borrow(borrow_w), .ready(ready_w));

  updown_counter_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .ENABLE_DLY(ENABLE_DLY), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset_n(reset_n), .load_en(load_en), .din(din), .inc_en(inc_en), .dec_en(dec_en),
    .dout(dout_s), .carry(carry_s), .borrow(borrow_s), .ready(ready_s));

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // behavioural model, updated on the same edges as the DUTs
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_edges = 0;
      for (int m = 0; m < 2; m++) begin
        for (int c = 0; c < NUM_CH; c++) begin
          m_val[m][c] = 0;
          m_car[m][c] = 1'b0;
          m_bor[m][c] = 1'b0;
        end
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        for (int c = 0; c < NUM_CH; c++) begin
          m_car[m][c] = 1'b0;
          m_bor[m][c] = 1'b0;
          if (m_edges >= ENABLE_DLY) begin
            if (load_en[c]) begin
              m_val[m][c] = int'(din[c*WIDTH +: WIDTH]);
            end else if (inc_en[c] && !dec_en[c]) begin
              if (m_val[m][c] == MAXV) begin
                m_car[m][c] = 1'b1;
                m_val[m][c] = (m == 1) ? MAXV : 0;
              end else begin
                m_val[m][c] = m_val[m][c] + 1;
              end
            end else if (dec_en[c] && !inc_en[c]) begin
              if (m_val[m][c] == 0) begin
                m_bor[m][c] = 1'b1;
                m_val[m][c] = (m == 1) ? 0 : MAXV;
              end else begin
                m_val[m][c] = m_val[m][c] - 1;
              end
            end
          end
        end
      end
      if (m_edges < ENABLE_DLY) m_edges = m_edges + 1;
    end
  end

  // compare both DUTs against the model on every falling edge
  always @(negedge clk) begin
    check("ready_wrap", 32'(ready_w), 32'(m_edges >= ENABLE_DLY));
    check("ready_sat", 32'(ready_s), 32'(m_edges >= ENABLE_DLY));
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("dout_wrap[%0d]", c), 32'(dout_w[c*WIDTH +: WIDTH]), 32'(m_val[0][c]));
      check($sformatf("dout_sat[%0d]", c), 32'(dout_s[c*WIDTH +: WIDTH]), 32'(m_val[1][c]));
      check($sformatf("carry_wrap[%0d]", c), 32'(carry_w[c]), 32'(m_car[0][c]));
      check($sformatf("carry_sat[%0d]", c), 32'(carry_s[c]), 32'(m_car[1][c]));
      check($sformatf("borrow_wrap[%0d]", c), 32'(borrow_w[c]), 32'(m_bor[0][c]));
      check($sformatf("borrow_sat[%0d]", c), 32'(borrow_s[c]), 32'(m_bor[1][c]));
    end
  end

  initial begin
    int exp_cnt[6];
    exp_cnt = '{0, 0, 0, 1, 2, 3};
    #1 reset_n = 1'b0;
    inc_en = '1;
    #11 reset_n = 1'b1;

    // reset release: counting held off for ENABLE_DLY edges
    for (int e = 0; e < 6; e++) begin
      step();
      check("rel_ready", 32'(ready_w), 32'(e >= 2));
      check("rel_dout0", 32'(dout_w[3:0]), 32'(exp_cnt[e]));
      check("rel_dout1", 32'(dout_w[7:4]), 32'(exp_cnt[e]));
    end

    // wrap and saturate at the extremes
    inc_en = '0;
    load_en = 4'b0011;
    din = {4'h0, 4'h0, 4'h0, 4'hE};
    step();
    load_en = '0; inc_en = 4'b0001; dec_en = 4'b0010;
    step();
    check("wrap_inc_F", 32'(dout_w[3:0]), 32'h0000_000F);
    check("wrap_carry_lo", 32'(carry_w[0]), 32'd0);
    check("wrap_dec_F", 32'(dout_w[7:4]), 32'h0000_000F);
    check("wrap_borrow", 32'(borrow_w[1]), 32'd1);
    check("sat_dec_hold0", 32'(dout_s[7:4]), 32'd0);
    check("sat_borrow", 32'(borrow_s[1]), 32'd1);
    dec_en = '0;
    step();
    check("wrap_inc_0", 32'(dout_w[3:0]), 32'd0);
    check("wrap_carry", 32'(carry_w[0]), 32'd1);
    check("wrap_borrow_end", 32'(borrow_w[1]), 32'd0);
    check("sat_inc_holdF", 32'(dout_s[3:0]), 32'h0000_000F);
    check("sat_carry", 32'(carry_s[0]), 32'd1);

    load_en = 4'b0011; inc_en = '0;
    din = {4'h0, 4'h0, 4'h0, 4'hF};
    step();
    load_en = '0; inc_en = 4'b0001; dec_en = 4'b0010;
    repeat (3) begin
      step();
      check("sat_rep_dout0", 32'(dout_s[3:0]), 32'h0000_000F);
      check("sat_rep_carry", 32'(carry_s[0]), 32'd1);
      check("sat_rep_dout1", 32'(dout_s[7:4]), 32'd0);
      check("sat_rep_borrow", 32'(borrow_s[1]), 32'd1);
    end
    inc_en = '0; dec_en = '0;
    step();
    check("sat_carry_drop", 32'(carry_s[0]), 32'd0);
    check("sat_borrow_drop", 32'(borrow_s[1]), 32'd0);

    // priority: load beats inc/dec, inc+dec holds
    load_en = 4'b0001; inc_en = 4'b0001; dec_en = 4'b0001;
    din = {4'h0, 4'h0, 4'h0, 4'h5};
    step();
    check("prio_load", 32'(dout_w[3:0]), 32'd5);
    check("prio_flags", 32'({carry_w[0], borrow_w[0]}), 32'd0);
    load_en = '0;
    step();
    check("prio_hold", 32'(dout_w[3:0]), 32'd5);
    check("prio_hold_flags", 32'({carry_w[0], borrow_w[0]}), 32'd0);

    // channel independence
    load_en = '1; inc_en = '0; dec_en = '0;
    din = {4'h3, 4'h3, 4'h3, 4'h3};
    step();
    load_en = 4'b0100; inc_en = 4'b0001; dec_en = 4'b0010;
    din = {4'h0, 4'hA, 4'h0, 4'h0};
    step();
    check("indep", 32'(dout_w), 32'h0000_3A24);

    // asynchronous reset between edges
    load_en = 4'b0001; inc_en = '0; dec_en = '0;
    din = {4'h0, 4'h0, 4'h0, 4'h9};
    step();
    check("pre_reset", 32'(dout_w[3:0]), 32'd9);
    load_en = '0;
    #2 reset_n = 1'b0;
    #1;
    check("async_dout", 32'(dout_w), 32'd0);
    check("async_ready", 32'(ready_w), 32'd0);
    #4 reset_n = 1'b1;
    inc_en = '1;
    repeat (ENABLE_DLY) begin
      step();
      check("reblock_dout", 32'(dout_w), 32'd0);
    end
    step();
    check("resume_count", 32'(dout_w), 32'h0000_1111);

    // randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 3000; i++) begin
      load_en = NUM_CH'($urandom & $urandom & $urandom);
      inc_en  = NUM_CH'($urandom);
      dec_en  = NUM_CH'($urandom);
      din     = DW'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 reset_n = 1'b0;
        #1;
        check("rand_async_dout", 32'(dout_s), 32'd0);
        #4 reset_n = 1'b1;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
